// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states and ASCII constants for the time-frame sender
//
// Purpose: common definitions for uart_time_sender and its digit converter.
// Ports:   none (package).

package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_DONE = 2'd2,
      FIN       = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   localparam int FRAME_LEN = 13;

endpackage

// File: rtl/uart_time_sender_bin2ascii_2dig.sv
// rtl/uart_time_sender_bin2ascii_2dig.sv - binary 0..127 to two ASCII decimal digits
//
// Purpose: converts one time field to tens/units ASCII characters; values
//          above 99 saturate to "99".
// Ports:
//   value  in   7  binary field value
//   tens   out  8  ASCII tens digit
//   units  out  8  ASCII units digit

module bin2ascii_2dig
   import uart_pkg::*;
(
   input  logic [6:0] value,
   output logic [7:0] tens,
   output logic [7:0] units
);

   logic [6:0] sat;
   logic [6:0] tens_bin;
   logic [6:0] units_bin;

   always_comb begin
      sat       = (value > 7'd99) ? 7'd99 : value;
      tens_bin  = sat / 7'd10;
      units_bin = sat % 7'd10;
      tens      = ASCII_0 + {1'b0, tens_bin};
      units     = ASCII_0 + {1'b0, units_bin};
   end

endmodule

// File: rtl/uart_time_sender.sv
// rtl/uart_time_sender.sv - serialises a time snapshot as "HH:MM:SS.CC\r\n" to the UART TX
//
// Purpose: on send_req, captures the time fields and issues the 13-byte ASCII
//          frame one byte at a time over the UART TX start/busy/done handshake,
//          aborting the frame if any byte waits TIMEOUT_CYC cycles.
// Ports:
//   clk       in   1  system clock
//   rst       in   1  asynchronous active-high reset
//   send_req  in   1  one-cycle request to send the current time
//   i_hour    in   5  hours
//   i_min     in   6  minutes
//   i_sec     in   6  seconds
//   i_csec    in   7  centiseconds
//   tx_busy   in   1  UART TX busy
//   tx_done   in   1  UART TX byte-complete pulse
//   tx_start  out  1  one-cycle start pulse to UART TX
//   tx_data   out  8  byte to transmit
//   busy      out  1  frame in progress
//   done      out  1  one-cycle pulse after the last byte completes
//   err       out  1  one-cycle pulse on timeout abort

module uart_time_sender
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYC = 200_000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       send_req,
   input  logic [4:0] i_hour,
   input  logic [5:0] i_min,
   input  logic [5:0] i_sec,
   input  logic [6:0] i_csec,
   input  logic       tx_busy,
   input  logic       tx_done,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [3:0]       LAST_IDX = 4'(FRAME_LEN - 1);

   state_t           state;
   logic [3:0]       index;
   logic [3:0]       next_index;
   logic [CNT_W-1:0] tmo_cnt;
   logic             timeout;

   logic [4:0] snap_hour;
   logic [5:0] snap_min;
   logic [5:0] snap_sec;
   logic [6:0] snap_csec;

   logic [6:0] f_hour;
   logic [6:0] f_min;
   logic [6:0] f_sec;
   logic [6:0] f_csec;

   logic [7:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u, csec_t, csec_u;
   logic [7:0] frame [16];

   // While idle the converters look at the live inputs so that byte 0 can be
   // loaded into tx_data on the same edge that captures the snapshot.
   always_comb begin
      if (state == IDLE) begin
         f_hour = {2'b00, i_hour};
         f_min  = {1'b0, i_min};
         f_sec  = {1'b0, i_sec};
         f_csec = i_csec;
      end else begin
         f_hour = {2'b00, snap_hour};
         f_min  = {1'b0, snap_min};
         f_sec  = {1'b0, snap_sec};
         f_csec = snap_csec;
      end
   end

   bin2ascii_2dig u_hour (.value(f_hour), .tens(hour_t), .units(hour_u));
   bin2ascii_2dig u_min  (.value(f_min),  .tens(min_t),  .units(min_u));
   bin2ascii_2dig u_sec  (.value(f_sec),  .tens(sec_t),  .units(sec_u));
   bin2ascii_2dig u_csec (.value(f_csec), .tens(csec_t), .units(csec_u));

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         frame[i] = 8'h00;
      end
      frame[0]  = hour_t;
      frame[1]  = hour_u;
      frame[2]  = ASCII_COLON;
      frame[3]  = min_t;
      frame[4]  = min_u;
      frame[5]  = ASCII_COLON;
      frame[6]  = sec_t;
      frame[7]  = sec_u;
      frame[8]  = ASCII_DOT;
      frame[9]  = csec_t;
      frame[10] = csec_u;
      frame[11] = ASCII_CR;
      frame[12] = ASCII_LF;
   end

   assign next_index = index + 4'd1;
   assign timeout    = (tmo_cnt == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         index     <= 4'd0;
         tmo_cnt   <= '0;
         snap_hour <= '0;
         snap_min  <= '0;
         snap_sec  <= '0;
         snap_csec <= '0;
         tx_start  <= 1'b0;
         tx_data   <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;

         case (state)
            IDLE: begin
               if (send_req) begin
                  snap_hour <= i_hour;
                  snap_min  <= i_min;
                  snap_sec  <= i_sec;
                  snap_csec <= i_csec;
                  index     <= 4'd0;
                  tmo_cnt   <= '0;
                  tx_data   <= frame[0];
                  busy      <= 1'b1;
                  state     <= SEND;
               end
            end

            SEND: begin
               if (timeout) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  index <= 4'd0;
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (!tx_busy) begin
                     tx_start <= 1'b1;
                     state    <= WAIT_DONE;
                  end
               end
            end

            WAIT_DONE: begin
               if (timeout) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  index <= 4'd0;
                  state <= IDLE;
               end else if (tx_done && !tx_start) begin
                  // A done coincident with our own start pulse belongs to an
                  // earlier transfer and is ignored.
                  if (index == LAST_IDX) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= FIN;
                  end else begin
                     index   <= next_index;
                     tx_data <= frame[next_index];
                     tmo_cnt <= '0;
                     state   <= SEND;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            FIN: begin
               index <= 4'd0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_time_sender.sv
// tb/tb_uart_time_sender.sv - directed scoreboard bench for uart_time_sender

module tb_uart_time_sender;

   logic       clk = 1'b0;
   logic       rst;
   logic       send_req;
   logic [4:0] i_hour;
   logic [5:0] i_min;
   logic [5:0] i_sec;
   logic [6:0] i_csec;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;
   logic       done;
   logic       err;

   uart_time_sender #(.TIMEOUT_CYC(500)) dut (
      .clk      (clk),
      .rst      (rst),
      .send_req (send_req),
      .i_hour   (i_hour),
      .i_min    (i_min),
      .i_sec    (i_sec),
      .i_csec   (i_csec),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_start, n_done, n_err;
   int done_cyc, err_cyc, last_done_cyc, ref_cyc, req_cyc;
   int pending = 0;
   int done_delay = 40;
   bit respond = 1'b1;
   bit busy_force = 1'b0;
   bit lat_en = 1'b0;
   logic prev_busy = 1'b0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_frame(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic set_time(input int h, input int m, input int s, input int c);
      i_hour = 5'(h);
      i_min  = 6'(m);
      i_sec  = 6'(s);
      i_csec = 7'(c);
   endtask

   // One clock: observe outputs at the falling edge, then drive the TX model.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (tx_start === 1'b1) begin
         n_start++;
         chk("tx_start_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            chk("tx_byte", 32'(tx_data), 32'(exp_b));
         end
         if (lat_en) chk("tx_start_latency", cyc - ref_cyc, 2);
         lat_en  = 1'b0;
         pending = done_delay;
      end
      if (done === 1'b1) begin
         n_done++;
         done_cyc = cyc;
         chk("busy_low_at_done", 32'(busy), 0);
         chk("busy_high_before_done", 32'(prev_busy), 1);
      end
      if (err === 1'b1) begin
         n_err++;
         err_cyc = cyc;
         chk("busy_low_at_err", 32'(busy), 0);
      end
      prev_busy = busy;
      tx_done = 1'b0;
      if (pending > 0) begin
         pending--;
         if (pending == 0 && respond) begin
            tx_done       = 1'b1;
            last_done_cyc = cyc;
            ref_cyc       = cyc;
            lat_en        = 1'b1;
         end
      end
      tx_busy = busy_force || (pending > 0);
   endtask

   task automatic send(input bit lat);
      n_start  = 0;
      n_done   = 0;
      n_err    = 0;
      req_cyc  = cyc;
      ref_cyc  = cyc;
      lat_en   = lat;
      send_req = 1'b1;
      step();
      send_req = 1'b0;
   endtask

   task automatic wait_frame(input int budget);
      int n = 0;
      while (n_done == 0 && n_err == 0 && n < budget) begin
         step();
         n++;
      end
      chk("frame_end_within_budget", 32'(n < budget), 1);
   endtask

   task automatic chk_frame(input string tag);
      chk({tag, "_starts"}, n_start, 13);
      chk({tag, "_done_count"}, n_done, 1);
      chk({tag, "_done_after_last_txdone"}, done_cyc - last_done_cyc, 1);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int  n;
      int  bad;
      bit  changed;
      bit  req2;

      rst = 1'b1;
      send_req = 1'b0;
      tx_busy = 1'b0;
      tx_done = 1'b0;
      set_time(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("reset_tx_start", 32'(tx_start), 0);
      chk("reset_tx_data", 32'(tx_data), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_err", 32'(err), 0);
      rst = 1'b0;
      repeat (2) step();

      // Basic frame
      set_time(12, 34, 56, 78);
      push_frame("12:34:56.78");
      send(1'b1);
      wait_frame(2000);
      chk_frame("basic");
      repeat (5) step();

      // Snapshot holds after input change; request mid-frame is dropped
      set_time(12, 34, 56, 78);
      push_frame("12:34:56.78");
      send(1'b1);
      changed = 1'b0;
      req2 = 1'b0;
      n = 0;
      while (n_done == 0 && n_err == 0 && n < 2000) begin
         step();
         n++;
         if (n_start == 3 && !changed) begin
            set_time(0, 0, 0, 0);
            changed = 1'b1;
         end
         if (n_start == 6 && !req2) begin
            req2 = 1'b1;
            send_req = 1'b1;
            step();
            send_req = 1'b0;
            n++;
         end
      end
      chk("snap_frame_end_within_budget", 32'(n < 2000), 1);
      chk_frame("snap");
      repeat (300) step();
      chk("snap_no_second_frame", n_start, 13);
      chk("snap_single_done", n_done, 1);

      // Saturation and zero padding
      set_time(0, 59, 9, 120);
      push_frame("00:59:09.99");
      send(1'b1);
      wait_frame(2000);
      chk_frame("sat");
      repeat (5) step();

      // Back-pressure at the start of SEND
      set_time(7, 8, 9, 10);
      push_frame("07:08:09.10");
      busy_force = 1'b1;
      tx_busy = 1'b1;
      send(1'b0);
      bad = 0;
      repeat (100) begin
         step();
         if (tx_data !== exp_q[0]) bad++;
      end
      chk("bp_no_start_while_busy", n_start, 0);
      chk("bp_data_stable", bad, 0);
      busy_force = 1'b0;
      wait_frame(2000);
      chk_frame("bp");
      repeat (5) step();

      // Timeout: TX never completes
      set_time(1, 2, 3, 4);
      push_frame("01:02:03.04");
      respond = 1'b0;
      send(1'b1);
      wait_frame(1000);
      chk("tmo_err_count", n_err, 1);
      chk("tmo_err_latency", err_cyc - req_cyc, 501);
      chk("tmo_no_done", n_done, 0);
      chk("tmo_single_start", n_start, 1);
      repeat (3) step();
      chk("tmo_err_single_pulse", n_err, 1);
      exp_q.delete();
      respond = 1'b1;
      push_frame("01:02:03.04");
      send(1'b1);
      wait_frame(2000);
      chk_frame("tmo_retry");
      chk("tmo_retry_no_err", n_err, 0);
      repeat (5) step();

      // Reset in the middle of byte 6
      set_time(10, 20, 30, 40);
      push_frame("10:20:30.40");
      send(1'b1);
      n = 0;
      while (n_start < 7 && n < 2000) begin
         step();
         n++;
      end
      chk("rst_reached_byte6", n_start, 7);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_tx_start", 32'(tx_start), 0);
      chk("rst_mid_tx_data", 32'(tx_data), 0);
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_done", 32'(done), 0);
      chk("rst_mid_err", 32'(err), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      pending = 0;
      tx_done = 1'b0;
      tx_busy = 1'b0;
      lat_en = 1'b0;
      repeat (5) step();
      chk("rst_no_done_pulse", n_done, 0);
      chk("rst_no_err_pulse", n_err, 0);
      set_time(23, 5, 41, 7);
      push_frame("23:05:41.07");
      send(1'b1);
      wait_frame(2000);
      chk_frame("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_time_sender.md
Name: uart_time_sender

Overview:
Upstream feeder for the UART transmitter. On a request it snapshots the current stopwatch/watch time and serialises it as a 13-byte ASCII frame, "HH:MM:SS.CC" followed by CR LF.
- Bytes are issued one at a time over the transmitter's tx_start / tx_data / tx_busy / tx_done handshake.
- The block sits between the stopwatch/watch core (time fields) and the UART TX.
- Requests come from the ASCII command decoder or from a button pulse.

Parameters:
- TIMEOUT_CYC, 200_000: maximum clk cycles to wait per byte for tx_done before the frame is aborted. Covers one 10-bit frame at 9600 baud / 100 MHz with margin.
- FRAME_LEN, 13: bytes per frame. Fixed; not for override.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- send_req  input  1  one-cycle request pulse to send the current time
- i_hour  input  5  hours, 0..31 accepted
- i_min  input  6  minutes, 0..63 accepted
- i_sec  input  6  seconds, 0..63 accepted
- i_csec  input  7  centiseconds, 0..127 accepted
- tx_busy  input  1  UART TX busy, from uart transmitter
- tx_done  input  1  UART TX one-cycle done pulse after stop bit
- tx_start  output  1  one-cycle start pulse to UART TX
- tx_data  output  8  byte to transmit
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse after the last byte's tx_done
- err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, rst=1): state IDLE; tx_start=0, tx_data=8'h00, busy=0, done=0, err=0; byte index=0, timeout count=0, snapshot regs=0. All outputs are registered.
- States: IDLE, SEND, WAIT_DONE, FIN.
- IDLE:
  - On send_req=1, capture i_hour/i_min/i_sec/i_csec into snapshot regs, index=0, busy=1, then go to SEND.
  - send_req outside IDLE is ignored. It is not queued.
- SEND:
  - tx_data is driven from frame[index] from the first SEND cycle onward and held stable until the next index change.
  - In the first SEND cycle where tx_busy=0, assert tx_start=1 for exactly one clk, then go to WAIT_DONE.
  - If tx_busy=1, remain in SEND with tx_start=0.
- WAIT_DONE:
  - On tx_done=1: if index==FRAME_LEN-1, go to FIN; else index+1 and go to SEND.
  - tx_done seen in the same cycle as tx_start is ignored.
- FIN: done=1 for one clk, busy=0, then go to IDLE.
- Timeout:
  - The counter clears on every entry to SEND and increments each cycle in SEND or WAIT_DONE.
  - At TIMEOUT_CYC-1: err=1 for one clk, busy=0, index=0, go to IDLE. done is not asserted.
- Latency:
  - send_req sampled at edge k.
  - tx_start=1 during cycle k+1 if tx_busy=0, with tx_data=hour tens char.
  - Inter-byte gap: tx_start for the next byte appears 1 clk after the tx_done cycle.
- Frame byte order, indices 0..12: Ht Hu ':' Mt Mu ':' St Su '.' Ct Cu 8'h0D 8'h0A.
- Digit rule:
  - Each field is converted as value 0..99 into tens = value/10 and units = value%10.
  - ASCII = 8'h30 + digit.
  - Field values >99 (only i_csec can reach 100..127) saturate to "99".
- Snapshot: input field changes after the capture edge do not affect the frame in flight.
- Reset mid-frame: an immediate abort to the reset values. No done or err pulse. The UART TX shares rst.

Decomposition:
- Shared package (uart_pkg) holds:
  - state encodings: IDLE=2'd0, SEND=2'd1, WAIT_DONE=2'd2, FIN=2'd3
  - constants ASCII_0=8'h30, ASCII_COLON=8'h3A, ASCII_DOT=8'h2E, ASCII_CR=8'h0D, ASCII_LF=8'h0A, FRAME_LEN=13
- One sub-module, bin2ascii_2dig: combinational. Takes a 7-bit input and produces two 8-bit ASCII digits, saturating at 99. Instantiated 4 times on the snapshot regs.

Test Plan:
- Basic frame: time 12:34:56.78, send_req pulse, TX model returns tx_done about 40 clk after each tx_start -> exactly 13 tx_start pulses with bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A; done pulses once, one clk after the 13th tx_done; busy falls with done.
- Snapshot and ignore: change the inputs to 00:00:00.00 after byte 2, and pulse send_req at byte 5 -> frame still carries 12:34:56.78; only one frame is sent; no second frame follows.
- Saturation and zero: time 00:59:09.120 -> bytes 30 30 3A 35 39 3A 30 39 2E 39 39 0D 0A.
- Back-pressure: tx_busy held 1 for 100 clk at the start of SEND -> no tx_start until tx_busy=0; then a single pulse; tx_data stable throughout.
- Timeout: TIMEOUT_CYC=500, TX model never asserts tx_done -> err pulse exactly 500 clk after entering SEND for byte 0; no done; busy=0; a new send_req then starts a fresh frame from byte 0.
- Reset mid-frame: assert rst during byte 6 -> tx_start, busy, done, err, tx_data all 0 asynchronously; after release, a send_req produces a full correct frame.
